amm_traffic_master: RTL

Avalon-MM burst master that turns test commands from the test sequencer into bus transactions toward the memory under test. It drives read, write, burstcount and byteenable, which the measurement stage taps. It runs write bursts with a deterministic data pattern and issues read bursts with bounded outstanding depth. It tracks returned read words and forwards them to the data checker.

---
 rtl/amm_traffic_master.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/amm_traffic_master.sv
// amm_traffic_master
//   Avalon-MM burst master driven by test commands. Write bursts carry a
//   deterministic incrementing pattern. Read bursts are requested with a
//   bounded number outstanding, and returned words are forwarded to the
//   data checker with burst framing.
//
// Ports
//   rst_i, clk_i          asynchronous active-high reset, clock
//   cmd_*                 command handshake: op, address, burstcount,
//                         byteenable, pattern seed
//   amm_*                 Avalon-MM master interface
//   rd_data_o/valid/last  returned read words, registered (1-cycle latency)
//   unexp_rd_o            sticky: readdatavalid with nothing outstanding
//   busy_o                registered: FSM active or reads outstanding
//
// state    | meaning
// IDLE     | waiting for a command; accepts when reads outstanding < max
// WR_BURST | presenting write beats until the last beat is accepted
// RD_REQ   | presenting one read request until it is accepted
module amm_traffic_master #(
    parameter int AMM_ADDR_W   = 32,
    parameter int AMM_DATA_W   = 128,
    parameter int AMM_BURST_W  = 11,
    parameter int MAX_RD_OUTST = 4
) (
    input  logic                    rst_i,
    input  logic                    clk_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_op_i,
    input  logic [AMM_ADDR_W-1:0]   cmd_addr_i,
    input  logic [AMM_BURST_W-1:0]  cmd_burstcount_i,
    input  logic [AMM_DATA_W/8-1:0] cmd_byteenable_i,
    input  logic [31:0]             cmd_seed_i,
    output logic [AMM_ADDR_W-1:0]   amm_address_o,
    output logic                    amm_read_o,
    output logic                    amm_write_o,
    output logic [AMM_BURST_W-1:0]  amm_burstcount_o,
    output logic [AMM_DATA_W/8-1:0] amm_byteenable_o,
    output logic [AMM_DATA_W-1:0]   amm_writedata_o,
    input  logic                    amm_waitrequest_i,
    input  logic                    amm_readdatavalid_i,
    input  logic [AMM_DATA_W-1:0]   amm_readdata_i,
    output logic [AMM_DATA_W-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    output logic                    rd_last_o,
    output logic                    unexp_rd_o,
    output logic                    busy_o
);

    localparam int LANES = AMM_DATA_W / 32;
    localparam int BE_W  = AMM_DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_RD_OUTST);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]       MAX_CNT = CNT_W'(MAX_RD_OUTST);
    localparam logic [AMM_BURST_W-1:0] BC_ONE  = AMM_BURST_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_REQ   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   write_q, write_d;
    logic                   read_q, read_d;
    logic [AMM_ADDR_W-1:0]  addr_q, addr_d;
    logic [AMM_BURST_W-1:0] bc_q, bc_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [31:0]            pat_q, pat_d;
    logic [AMM_BURST_W-1:0] beat_q, beat_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       outst_q, outst_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AMM_BURST_W-1:0] fifo_q [MAX_RD_OUTST];
    logic [AMM_BURST_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [AMM_DATA_W-1:0]  rd_data_q;
    logic                   rd_valid_q;
    logic                   rd_last_q;
    logic                   unexp_q, unexp_d;

    logic                   cmd_acc;
    logic                   rd_push;
    logic                   rd_pop;
    logic                   fifo_empty;
    logic [AMM_BURST_W-1:0] head;

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        read_d   = read_q;
        addr_d   = addr_q;
        bc_d     = bc_q;
        be_d     = be_q;
        pat_d    = pat_q;
        beat_d   = beat_q;
        rx_cnt_d = rx_cnt_q;
        unexp_d  = unexp_q;
        outst_d  = outst_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        cmd_acc    = cmd_valid_i && ready_q;
        rd_push    = read_q && !amm_waitrequest_i;
        fifo_empty = (outst_q == '0);
        head       = fifo_q[rd_ptr_q];
        rd_pop     = amm_readdatavalid_i && !fifo_empty && (rx_cnt_q == head - BC_ONE);

        case (state_q)
            IDLE: begin
                // Zero-length commands are consumed without touching the bus.
                if (cmd_acc && (cmd_burstcount_i != '0)) begin
                    addr_d = cmd_addr_i;
                    bc_d   = cmd_burstcount_i;
                    if (cmd_op_i) begin
                        state_d = WR_BURST;
                        write_d = 1'b1;
                        be_d    = cmd_byteenable_i;
                        pat_d   = cmd_seed_i;
                        beat_d  = '0;
                    end else begin
                        state_d = RD_REQ;
                        read_d  = 1'b1;
                        be_d    = '1;
                    end
                end
            end
            WR_BURST: begin
                if (!amm_waitrequest_i) begin
                    if (beat_q == bc_q - BC_ONE) begin
                        write_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BC_ONE;
                        pat_d  = pat_q + 32'd1;
                    end
                end
            end
            RD_REQ: begin
                if (!amm_waitrequest_i) begin
                    read_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
                read_d  = 1'b0;
            end
        endcase

        if (amm_readdatavalid_i) begin
            if (fifo_empty) begin
                unexp_d = 1'b1;
            end else if (rd_pop) begin
                rx_cnt_d = '0;
            end else begin
                rx_cnt_d = rx_cnt_q + BC_ONE;
            end
        end

        if (rd_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // A push and pop in the same cycle leave the count unchanged.
        case ({rd_push, rd_pop})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        // Ready is registered from next state so it reflects the state/count pair.
        ready_d = (state_d == IDLE) && (outst_d < MAX_CNT);
        busy_d  = (state_q != IDLE) || (outst_q != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= '0;
            bc_q       <= '0;
            be_q       <= '0;
            pat_q      <= '0;
            beat_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            outst_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            unexp_q    <= 1'b0;
            for (int i = 0; i < MAX_RD_OUTST; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            bc_q       <= bc_d;
            be_q       <= be_d;
            pat_q      <= pat_d;
            beat_q     <= beat_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            outst_q    <= outst_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rx_cnt_q   <= rx_cnt_d;
            rd_data_q  <= amm_readdata_i;
            rd_valid_q <= amm_readdatavalid_i;
            rd_last_q  <= rd_pop;
            unexp_q    <= unexp_d;
            if (rd_push) fifo_q[wr_ptr_q] <= bc_q;
        end
    end

    assign cmd_ready_o      = ready_q;
    assign amm_address_o    = addr_q;
    assign amm_read_o       = read_q;
    assign amm_write_o      = write_q;
    assign amm_burstcount_o = bc_q;
    assign amm_byteenable_o = be_q;
    assign amm_writedata_o  = {LANES{pat_q}};
    assign rd_data_o        = rd_data_q;
    assign rd_valid_o       = rd_valid_q;
    assign rd_last_o        = rd_last_q;
    assign unexp_rd_o       = unexp_q;
    assign busy_o           = busy_q;

endmodule
